// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
//   state_t    : sequencer state encoding (2'd3 is unused and recovers to IDLE)
//   MUL_WIDTH  : default operand/result width
//   MUL_CNTW   : default iteration counter width, wide enough to hold MUL_WIDTH
package mul_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MUL_WIDTH = 64;
  localparam int MUL_CNTW  = $clog2(MUL_WIDTH) + 1;

endpackage

// File: rtl/mul_seq_ctrl_adder.sv
// Plain ripple-style WIDTH-bit adder shared by the multiplier datapath.
// Ports:
//   a, b  : addends
//   cin   : carry in
//   sum   : a + b + cin, modulo 2^WIDTH
//   cout  : carry out of the top bit
module mul_seq_ctrl_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for a radix-2 shift-add multiplier (low WIDTH bits of a*b).
// One conditional accumulate per multiplier bit through a single shared adder.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; result holds the last product
// RUN     | WIDTH iterations of accumulate / shift
// DONE    | one-cycle done pulse, result valid
//
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high reset
//   start   : request, sampled only in IDLE
//   kill    : abort / pipeline flush, overrides start and sequencing
//   op_a    : multiplicand, captured with start
//   op_b    : multiplier, captured with start
//   busy    : high in RUN and DONE
//   done    : one-cycle pulse while the result is valid
//   result  : product low bits, held until the next accepted start
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNTW  = MUL_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] sum;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] acc_next;

  mul_seq_ctrl_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout ()
  );

  // Accumulator value after this cycle's iteration; also the final product
  // on the last iteration, so result can be loaded on entry to DONE.
  assign acc_next = mplier[0] ? sum : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start && !kill) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= '0;
            result <= '0;
            busy_r <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (kill) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              result <= acc_next;
              done_r <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  // A flush arriving during the DONE cycle must squash the pulse in that
  // same cycle, so the registered pulse is gated by kill.
  assign done = done_r & ~kill;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

  localparam int W = 64;
  localparam int LAT = W + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic         kill;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int tests;
  int failed;

  mul_seq_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .kill   (kill),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called at a negative edge with the sequencer idle. Presents start for
  // one cycle and observes busy/done until busy drops.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int bcyc,
                        output int pulses, output int done_at, output bit tmo);
    int guard;
    bit prev_done;
    res = 'x; bcyc = 0; pulses = 0; done_at = -1; tmo = 0; guard = 0;
    prev_done = 0;
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    while (busy && guard < 300) begin
      bcyc++;
      if (done) begin
        if (!prev_done) pulses++;
        else pulses += 100;
        res = result;
        done_at = bcyc;
      end
      prev_done = done;
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) tmo = 1;
  endtask

  // Reference: low W bits of the product by plain arithmetic.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return a * b;
  endfunction

  logic [W-1:0] res;
  int bcyc, pulses, done_at, cnt_done, guard;
  bit tmo;

  initial begin
    tests = 0; failed = 0;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op_a = '0; op_b = '0;

    vecs[0] = '{64'd3, 64'd5, 64'd15};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    vecs[2] = '{64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_EDCC};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0};
    vecs[4] = '{64'd0, 64'hDEAD, 64'd0};
    vecs[5] = '{64'd7, 64'd6, 64'd42};
    vecs[6] = '{64'd9, 64'd9, 64'd81};

    #22;
    chk("reset_busy", W'(busy), 0);
    chk("reset_done", W'(done), 0);
    chk("reset_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_mul(vecs[i].a, vecs[i].b, res, bcyc, pulses, done_at, tmo);
      chk($sformatf("vec%0d_timeout", i), W'(tmo), 0);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_busy_cycles", i), W'(bcyc), W'(LAT));
      chk($sformatf("vec%0d_done_pulses", i), W'(pulses), 1);
      chk($sformatf("vec%0d_done_last_busy", i), W'(done_at), W'(LAT));
      chk($sformatf("vec%0d_held", i), result, vecs[i].exp);
    end

    // Reset mid-run
    start = 1'b1; op_a = 3; op_b = 5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", W'(busy), 0);
    chk("midrst_done", W'(done), 0);
    chk("midrst_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt_done = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done || busy) cnt_done++;
    end
    chk("midrst_no_activity", W'(cnt_done), 0);

    // Kill in RUN; result was cleared by the accepted start and a killed
    // run never writes a product, so it stays at the cleared value.
    do_mul(64'd7, 64'd6, res, bcyc, pulses, done_at, tmo);
    chk("prekill_result", res, 64'd42);
    start = 1'b1; op_a = 11; op_b = 13;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", W'(busy), 0);
    chk("kill_result", result, 0);
    do_mul(64'd2, 64'd21, res, bcyc, pulses, done_at, tmo);
    chk("postkill_result", res, 64'd42);
    chk("postkill_busy_cycles", W'(bcyc), W'(LAT));
    chk("postkill_pulses", W'(pulses), 1);

    // Kill in the DONE cycle squashes the pulse
    start = 1'b1; op_a = 5; op_b = 5;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("killdone_reach", W'(guard < 200), 1);
    kill = 1'b1;
    #1;
    chk("killdone_done", W'(done), 0);
    @(negedge clk);
    kill = 1'b0;
    chk("killdone_busy", W'(busy), 0);

    // Kill in IDLE blocks start
    start = 1'b1; kill = 1'b1; op_a = 4; op_b = 4;
    @(negedge clk);
    chk("idlekill_busy", W'(busy), 0);
    start = 1'b0; kill = 1'b0;
    @(negedge clk);

    // start held across two operations
    start = 1'b1; op_a = 7; op_b = 6;
    @(negedge clk);
    op_a = 9; op_b = 9;
    chk("held_busy1", W'(busy), 1);
    guard = 0; bcyc = 0;
    while (busy && !done && guard < 200) begin
      bcyc++; @(negedge clk); guard++;
    end
    bcyc++;
    chk("held_first_result", result, 64'd42);
    chk("held_first_done", W'(done), 1);
    chk("held_first_busy_cycles", W'(bcyc), W'(LAT));
    @(negedge clk);
    chk("held_idle_gap", W'(busy), 0);
    @(negedge clk);
    chk("held_second_accept", W'(busy), 1);
    guard = 0;
    while (busy && !done && guard < 200) begin
      @(negedge clk); guard++;
    end
    chk("held_second_done", W'(done), 1);
    chk("held_second_result", result, 64'd81);
    start = 1'b0;
    @(negedge clk);

    // Randomized against reference model
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: a = '0;
        1: b = '1;
        2: b = W'($urandom_range(0, 255));
        default: ;
      endcase
      do_mul(a, b, res, bcyc, pulses, done_at, tmo);
      chk($sformatf("rnd%0d_result", n), res, ref_mul(a, b));
      chk($sformatf("rnd%0d_pulses", n), W'(pulses), 1);
      chk($sformatf("rnd%0d_busy_cycles", n), W'(bcyc), W'(LAT));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
